// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin REQ#/GNT# arbitration with no bus
// parking, FRAME#/IRDY# ownership tracking and revocation of grants that
// are never used.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   req_n     per-master bus request, active low
//   frame_n   PCI FRAME#, active low
//   irdy_n    PCI IRDY#, active low
//   gnt_n     per-master grant, active low, registered, one-hot-low or all high
//   gnt_id    index of the current or most recent grant holder
//   bus_busy  high while the owner's transaction is in progress
//   timeout   one-cycle pulse when a grant is revoked for inactivity
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; grant the next requester once the bus is idle
// GRANT | owner granted, waiting for FRAME#; counts toward revocation
// BUSY  | owner's transaction in progress; hold grant until bus idle
// TURN  | single turnaround cycle with all grants high, then arbitrate

module pci_bus_arbiter #(
   parameter int NUM_MASTERS  = 4,
   parameter int IDLE_TIMEOUT = 16,
   localparam int ID_W  = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1,
   localparam int CNT_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] req_n,
   input  logic                   frame_n,
   input  logic                   irdy_n,
   output logic [NUM_MASTERS-1:0] gnt_n,
   output logic [ID_W-1:0]        gnt_id,
   output logic                   bus_busy,
   output logic                   timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2,
      TURN  = 2'd3
   } state_t;

   state_t                 state, state_nxt;
   logic [ID_W-1:0]        last, last_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [NUM_MASTERS-1:0] gnt_n_nxt;
   logic [ID_W-1:0]        gnt_id_nxt;
   logic                   bus_busy_nxt;
   logic                   timeout_nxt;

   logic                   bus_idle;
   logic                   win_vld;
   logic [ID_W-1:0]        win_id;

   assign bus_idle = frame_n & irdy_n;

   // Round-robin search starting just after the last winner. Scanning from
   // the farthest candidate to the nearest lets the nearest one overwrite.
   always_comb begin
      int idx;
      idx     = 0;
      win_vld = 1'b0;
      win_id  = '0;
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         idx = (int'(last) + i) % NUM_MASTERS;
         if (!req_n[idx]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last     <= ID_W'(NUM_MASTERS - 1);
         cnt      <= '0;
         gnt_n    <= '1;
         gnt_id   <= '0;
         bus_busy <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         cnt      <= cnt_nxt;
         gnt_n    <= gnt_n_nxt;
         gnt_id   <= gnt_id_nxt;
         bus_busy <= bus_busy_nxt;
         timeout  <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      last_nxt     = last;
      cnt_nxt      = cnt;
      gnt_n_nxt    = gnt_n;
      gnt_id_nxt   = gnt_id;
      bus_busy_nxt = bus_busy;
      timeout_nxt  = 1'b0;

      unique case (state)
         IDLE, TURN: begin
            gnt_n_nxt = '1;
            if (bus_idle && win_vld) begin
               state_nxt          = GRANT;
               gnt_n_nxt[win_id]  = 1'b0;
               gnt_id_nxt         = win_id;
               last_nxt           = win_id;
               cnt_nxt            = '0;
            end else begin
               state_nxt = IDLE;
            end
         end

         GRANT: begin
            // FRAME# wins over both withdrawal and the revocation edge.
            if (!frame_n) begin
               state_nxt    = BUSY;
               bus_busy_nxt = 1'b1;
            end else if (req_n[gnt_id]) begin
               state_nxt = TURN;
               gnt_n_nxt = '1;
            end else if (cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
               state_nxt   = TURN;
               gnt_n_nxt   = '1;
               timeout_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         BUSY: begin
            if (bus_idle) begin
               state_nxt    = TURN;
               gnt_n_nxt    = '1;
               bus_busy_nxt = 1'b0;
            end
         end

         default: begin
            state_nxt = IDLE;
            gnt_n_nxt = '1;
         end
      endcase
   end

endmodule
